mips_mem_arbiter: RTL and testbench

- Owns the unified 32-bit instruction/data memory of the pipelined MIPS32 core.
- Shares its single port between three requesters:
  - instruction fetch (IF stage)
  - data access (LW/SW from the MEM stage)
  - an external program loader
- Fixed priority with fetch anti-starvation; a mode FSM hands the port to the loader while the CPU is stalled.
- Sits between the core pipeline registers and the storage array; the array is instantiated inside this block.

---
 rtl/mips_mem_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_mips_mem_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter: unified instruction/data memory with a single shared port.
// Requesters: instruction fetch, data access (LW/SW) and an external loader.
// Fixed priority (data over fetch) with fetch anti-starvation after MAX_WAIT
// consecutive denials; a RUN/DRAIN/LOAD mode FSM hands the port to the loader
// while the core is stalled.
// Optional build macro: ARB_STATS_EN adds saturating grant/conflict counters.
//
// Handshake: a requester holds req until it sees gnt in the same cycle; the
// granted access takes effect at the next clk1 edge; reads return rvalid for
// exactly one cycle after the grant with registered rdata that holds until the
// next rvalid of that requester; writes never produce rvalid.
module mips_mem_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 9,
  parameter int DEPTH    = 501,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk1,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  input  logic              ld_mode,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              cpu_stall,
  output logic              addr_err,
  output logic [15:0]       stat_if_cnt,
  output logic [15:0]       stat_dm_cnt,
  output logic [15:0]       stat_conf_cnt,
  output logic [1:0]        state_dbg
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0]   WAIT_MAX  = WW'(MAX_WAIT);
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    LOAD  = 2'd2
  } mode_t;

  mode_t             state, state_nx;
  logic [WW-1:0]     wait_cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              acc_valid;
  logic              acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              acc_in_range;
  logic [DATA_W-1:0] rd_word;

  logic if_rvalid_q, dm_rvalid_q, ld_rvalid_q;

  assign state_dbg = state;

  // Mode FSM next state and single-winner grant selection.
  always_comb begin
    state_nx = state;
    if_gnt   = 1'b0;
    dm_gnt   = 1'b0;
    ld_gnt   = 1'b0;
    case (state)
      RUN: begin
        if (if_req && wait_cnt == WAIT_MAX) if_gnt = 1'b1;
        else if (dm_req)                     dm_gnt = 1'b1;
        else if (if_req)                     if_gnt = 1'b1;
        if (ld_mode) state_nx = DRAIN;
      end
      DRAIN: state_nx = ld_mode ? LOAD : RUN;
      LOAD: begin
        ld_gnt = ld_req;
        if (!ld_mode) state_nx = RUN;
      end
      default: state_nx = RUN;
    endcase
  end

  // Steer the winning requester onto the memory port and do the array read.
  always_comb begin
    acc_valid = if_gnt | dm_gnt | ld_gnt;
    acc_we    = 1'b0;
    acc_addr  = if_addr;
    acc_wdata = '0;
    if (ld_gnt) begin
      acc_we    = ld_we;
      acc_addr  = ld_addr;
      acc_wdata = ld_wdata;
    end else if (dm_gnt) begin
      acc_we    = dm_we;
      acc_addr  = dm_addr;
      acc_wdata = dm_wdata;
    end
    acc_in_range = ({1'b0, acc_addr} < DEPTH_LIM);
    rd_word      = acc_in_range ? mem[acc_addr] : '0;
  end

  // Storage array: not reset; out-of-range and reset-cycle writes are dropped.
  always_ff @(posedge clk1) begin
    if (!reset && acc_valid && acc_we && acc_in_range) mem[acc_addr] <= acc_wdata;
  end

  // Mode state, stall, starvation counter, read returns and address error.
  always_ff @(posedge clk1) begin
    if (reset) begin
      state       <= RUN;
      cpu_stall   <= 1'b0;
      wait_cnt    <= '0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      ld_rvalid_q <= 1'b0;
      if_rdata    <= '0;
      dm_rdata    <= '0;
      ld_rdata    <= '0;
      addr_err    <= 1'b0;
    end else begin
      state     <= state_nx;
      cpu_stall <= (state_nx != RUN);
      if (state == RUN && if_req && !if_gnt) begin
        if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 1'b1;
      end else if (if_gnt || !if_req) begin
        wait_cnt <= '0;
      end
      if_rvalid_q <= if_gnt;
      dm_rvalid_q <= dm_gnt && !dm_we;
      ld_rvalid_q <= ld_gnt && !ld_we;
      if (if_gnt)            if_rdata <= rd_word;
      if (dm_gnt && !dm_we)  dm_rdata <= rd_word;
      if (ld_gnt && !ld_we)  ld_rdata <= rd_word;
      addr_err <= acc_valid && !acc_in_range;
    end
  end

  // A read still in flight when reset arrives never reports valid.
  assign if_rvalid = if_rvalid_q & ~reset;
  assign dm_rvalid = dm_rvalid_q & ~reset;
  assign ld_rvalid = ld_rvalid_q & ~reset;

`ifdef ARB_STATS_EN
  logic [15:0] if_cnt_q, dm_cnt_q, conf_cnt_q;

  // Saturating grant and fetch/data conflict counters.
  always_ff @(posedge clk1) begin
    if (reset) begin
      if_cnt_q   <= '0;
      dm_cnt_q   <= '0;
      conf_cnt_q <= '0;
    end else begin
      if (if_gnt && if_cnt_q != 16'hFFFF) if_cnt_q <= if_cnt_q + 16'd1;
      if (dm_gnt && dm_cnt_q != 16'hFFFF) dm_cnt_q <= dm_cnt_q + 16'd1;
      if (state == RUN && if_req && dm_req && conf_cnt_q != 16'hFFFF)
        conf_cnt_q <= conf_cnt_q + 16'd1;
    end
  end

  assign stat_if_cnt   = if_cnt_q;
  assign stat_dm_cnt   = dm_cnt_q;
  assign stat_conf_cnt = conf_cnt_q;
`else
  assign stat_if_cnt   = '0;
  assign stat_dm_cnt   = '0;
  assign stat_conf_cnt = '0;
`endif

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Testbench for mips_mem_arbiter: directed scenarios plus a randomized
// two-requester run scored against a queue-based reference model.
module tb_mips_mem_arbiter;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 9;
  localparam int DEPTH    = 501;
  localparam int MAX_WAIT = 4;

  logic              clk1 = 1'b0;
  logic              reset;
  logic              if_req, if_gnt, if_rvalid;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata, dm_rdata;
  logic              ld_mode, ld_req, ld_we, ld_gnt, ld_rvalid;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata, ld_rdata;
  logic              cpu_stall, addr_err;
  logic [15:0]       stat_if_cnt, stat_dm_cnt, stat_conf_cnt;
  logic [1:0]        state_dbg;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic [DATA_W-1:0] if_q[$];
  logic [DATA_W-1:0] dm_q[$];
  int exp_if_cnt, exp_dm_cnt, exp_conf_cnt;

  mips_mem_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk1(clk1), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .ld_mode(ld_mode), .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr),
    .ld_wdata(ld_wdata), .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .cpu_stall(cpu_stall), .addr_err(addr_err),
    .stat_if_cnt(stat_if_cnt), .stat_dm_cnt(stat_dm_cnt), .stat_conf_cnt(stat_conf_cnt),
    .state_dbg(state_dbg)
  );

  // Clock and watchdog
  always #5 clk1 = ~clk1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance to just after the next active edge; inputs are driven here.
  task automatic cyc();
    @(posedge clk1);
    #1;
  endtask

  task automatic idle();
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; ld_req = 1'b0; ld_we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; ld_mode = 1'b0; idle();
    if_addr = '0; dm_addr = '0; dm_wdata = '0; ld_addr = '0; ld_wdata = '0;
    repeat (3) cyc();
    n_cmp++; if ({if_rvalid, dm_rvalid, ld_rvalid} !== 3'b000) begin
      n_bad++; $display("FAIL reset_rvalid got %b exp 000", {if_rvalid, dm_rvalid, ld_rvalid}); end
    n_cmp++; if ({if_rdata, dm_rdata, ld_rdata} !== 96'd0) begin
      n_bad++; $display("FAIL reset_rdata got %h exp 0", {if_rdata, dm_rdata, ld_rdata}); end
    n_cmp++; if (cpu_stall !== 1'b0) begin
      n_bad++; $display("FAIL reset_stall got %b exp 0", cpu_stall); end
    n_cmp++; if (addr_err !== 1'b0) begin
      n_bad++; $display("FAIL reset_addr_err got %b exp 0", addr_err); end
    n_cmp++; if ({stat_if_cnt, stat_dm_cnt, stat_conf_cnt} !== 48'd0) begin
      n_bad++; $display("FAIL reset_stats got %h exp 0", {stat_if_cnt, stat_dm_cnt, stat_conf_cnt}); end
    n_cmp++; if (state_dbg !== 2'd0) begin
      n_bad++; $display("FAIL reset_state got %0d exp 0 (RUN)", state_dbg); end
    reset = 1'b0;
    exp_if_cnt = 0; exp_dm_cnt = 0; exp_conf_cnt = 0;
    cyc();
  endtask

  task automatic test_store_fetch();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 9'd5; dm_wdata = 32'hDEAD_BEEF;
    @(negedge clk1);
    n_cmp++; if ({if_gnt, dm_gnt} !== 2'b01) begin
      n_bad++; $display("FAIL sf_store_gnt got %b exp 01", {if_gnt, dm_gnt}); end
    cyc();
    ref_mem[5] = 32'hDEAD_BEEF; exp_dm_cnt++;
    dm_req = 1'b0; dm_we = 1'b0; if_req = 1'b1; if_addr = 9'd5;
    @(negedge clk1);
    n_cmp++; if (if_gnt !== 1'b1) begin
      n_bad++; $display("FAIL sf_fetch_gnt got %b exp 1", if_gnt); end
    cyc();
    exp_if_cnt++;
    if_req = 1'b0;
    n_cmp++; if (if_rvalid !== 1'b1 || if_rdata !== 32'hDEAD_BEEF) begin
      n_bad++; $display("FAIL sf_fetch_data got v=%b d=%h exp v=1 d=deadbeef", if_rvalid, if_rdata); end
    n_cmp++; if (dm_rvalid !== 1'b0) begin
      n_bad++; $display("FAIL sf_store_no_rvalid got %b exp 0", dm_rvalid); end
    cyc();
    n_cmp++; if (if_rvalid !== 1'b0 || if_rdata !== 32'hDEAD_BEEF) begin
      n_bad++; $display("FAIL sf_rvalid_pulse got v=%b d=%h exp v=0 d=deadbeef", if_rvalid, if_rdata); end
  endtask

  task automatic test_starvation();
    int denied;
    logic exp_if;
    int e_if, e_dm, e_cf;
    denied = 0;
    if_req = 1'b1; if_addr = 9'd5; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 9'd5;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk1);
      exp_if = (denied == MAX_WAIT);
      n_cmp++; if ({if_gnt, dm_gnt} !== {exp_if, ~exp_if}) begin
        n_bad++; $display("FAIL starve_cycle%0d got if=%b dm=%b exp if=%b dm=%b", k, if_gnt, dm_gnt, exp_if, ~exp_if); end
      denied = exp_if ? 0 : denied + 1;
      if (exp_if) exp_if_cnt++; else exp_dm_cnt++;
      exp_conf_cnt++;
      cyc();
    end
    idle();
    cyc();
    e_if = exp_if_cnt; e_dm = exp_dm_cnt; e_cf = exp_conf_cnt;
`ifndef ARB_STATS_EN
    e_if = 0; e_dm = 0; e_cf = 0;
`endif
    n_cmp++; if ({stat_if_cnt, stat_dm_cnt, stat_conf_cnt} !== {e_if[15:0], e_dm[15:0], e_cf[15:0]}) begin
      n_bad++; $display("FAIL starve_stats got %0d/%0d/%0d exp %0d/%0d/%0d",
        stat_if_cnt, stat_dm_cnt, stat_conf_cnt, e_if, e_dm, e_cf); end
  endtask

  task automatic test_loader();
    logic [DATA_W-1:0] v7;
    logic [DATA_W-1:0] w [3];
    v7 = $urandom | 32'h1;
    for (int i = 0; i < 3; i++) w[i] = $urandom | 32'h100;
    // Store a known word at 7, then load it in the cycle ld_mode rises.
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 9'd7; dm_wdata = v7;
    @(negedge clk1);
    n_cmp++; if (dm_gnt !== 1'b1) begin
      n_bad++; $display("FAIL ld_pre_store_gnt got %b exp 1", dm_gnt); end
    cyc();
    ref_mem[7] = v7; exp_dm_cnt++;
    dm_we = 1'b0; ld_mode = 1'b1;
    @(negedge clk1);
    n_cmp++; if (dm_gnt !== 1'b1) begin
      n_bad++; $display("FAIL ld_mode_edge_gnt got %b exp 1", dm_gnt); end
    cyc();
    exp_dm_cnt++;
    // DRAIN: the load returns, nobody is granted.
    dm_req = 1'b0; if_req = 1'b1; if_addr = 9'd0;
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 9'd0; ld_wdata = w[0];
    n_cmp++; if (dm_rvalid !== 1'b1 || dm_rdata !== v7) begin
      n_bad++; $display("FAIL drain_rvalid got v=%b d=%h exp v=1 d=%h", dm_rvalid, dm_rdata, v7); end
    n_cmp++; if (cpu_stall !== 1'b1) begin
      n_bad++; $display("FAIL drain_stall got %b exp 1", cpu_stall); end
    @(negedge clk1);
    n_cmp++; if ({if_gnt, dm_gnt, ld_gnt} !== 3'b000) begin
      n_bad++; $display("FAIL drain_no_gnt got %b exp 000", {if_gnt, dm_gnt, ld_gnt}); end
    cyc();
    // LOAD: three loader writes while fetch keeps requesting.
    for (int i = 0; i < 3; i++) begin
      ld_addr = 9'(i); ld_wdata = w[i];
      @(negedge clk1);
      n_cmp++; if ({if_gnt, ld_gnt} !== 2'b01) begin
        n_bad++; $display("FAIL load_wr%0d_gnt got if=%b ld=%b exp if=0 ld=1", i, if_gnt, ld_gnt); end
      cyc();
      ref_mem[i] = w[i];
    end
    n_cmp++; if (cpu_stall !== 1'b1) begin
      n_bad++; $display("FAIL load_stall got %b exp 1", cpu_stall); end
    ld_we = 1'b0; ld_addr = 9'd1;
    @(negedge clk1);
    n_cmp++; if (ld_gnt !== 1'b1) begin
      n_bad++; $display("FAIL load_rd_gnt got %b exp 1", ld_gnt); end
    cyc();
    // Exit cycle: loader drops req and mode.
    ld_mode = 1'b0; ld_req = 1'b0;
    n_cmp++; if (ld_rvalid !== 1'b1 || ld_rdata !== w[1]) begin
      n_bad++; $display("FAIL load_rd_data got v=%b d=%h exp v=1 d=%h", ld_rvalid, ld_rdata, w[1]); end
    @(negedge clk1);
    n_cmp++; if ({if_gnt, dm_gnt, ld_gnt} !== 3'b000) begin
      n_bad++; $display("FAIL load_exit_no_gnt got %b exp 000", {if_gnt, dm_gnt, ld_gnt}); end
    cyc();
    n_cmp++; if (cpu_stall !== 1'b0 || ld_rvalid !== 1'b0) begin
      n_bad++; $display("FAIL run_return got stall=%b ld_rvalid=%b exp 0 0", cpu_stall, ld_rvalid); end
    // Back in RUN: fetch reads back the loaded words.
    for (int i = 0; i < 3; i++) begin
      if_addr = 9'(i);
      @(negedge clk1);
      n_cmp++; if (if_gnt !== 1'b1) begin
        n_bad++; $display("FAIL readback%0d_gnt got %b exp 1", i, if_gnt); end
      cyc();
      exp_if_cnt++;
      n_cmp++; if (if_rvalid !== 1'b1 || if_rdata !== ref_mem[i]) begin
        n_bad++; $display("FAIL readback%0d_data got v=%b d=%h exp v=1 d=%h", i, if_rvalid, if_rdata, ref_mem[i]); end
    end
    if_req = 1'b0;
    cyc();
  endtask

  task automatic test_out_of_range();
    int chk [5] = '{0, 1, 2, 5, 7};
    if_req = 1'b1; if_addr = 9'd510;
    @(negedge clk1);
    n_cmp++; if (if_gnt !== 1'b1) begin
      n_bad++; $display("FAIL oor_fetch_gnt got %b exp 1", if_gnt); end
    cyc();
    exp_if_cnt++;
    if_req = 1'b0;
    n_cmp++; if (if_rvalid !== 1'b1 || if_rdata !== 32'd0 || addr_err !== 1'b1) begin
      n_bad++; $display("FAIL oor_fetch got v=%b d=%h err=%b exp v=1 d=0 err=1", if_rvalid, if_rdata, addr_err); end
    cyc();
    n_cmp++; if (addr_err !== 1'b0) begin
      n_bad++; $display("FAIL oor_err_pulse got %b exp 0", addr_err); end
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 9'd505; dm_wdata = 32'hA5A5_5A5A;
    @(negedge clk1);
    n_cmp++; if (dm_gnt !== 1'b1) begin
      n_bad++; $display("FAIL oor_store_gnt got %b exp 1", dm_gnt); end
    cyc();
    exp_dm_cnt++;
    dm_we = 1'b0; dm_addr = 9'd505;
    n_cmp++; if (addr_err !== 1'b1) begin
      n_bad++; $display("FAIL oor_store_err got %b exp 1", addr_err); end
    cyc();
    exp_dm_cnt++;
    dm_req = 1'b0;
    n_cmp++; if (dm_rvalid !== 1'b1 || dm_rdata !== 32'd0) begin
      n_bad++; $display("FAIL oor_load got v=%b d=%h exp v=1 d=0", dm_rvalid, dm_rdata); end
    for (int i = 0; i < 5; i++) begin
      if_req = 1'b1; if_addr = 9'(chk[i]);
      cyc();
      exp_if_cnt++;
      if_req = 1'b0;
      n_cmp++; if (if_rdata !== ref_mem[chk[i]] || addr_err !== 1'b0) begin
        n_bad++; $display("FAIL oor_intact_w%0d got d=%h err=%b exp d=%h err=0", chk[i], if_rdata, addr_err, ref_mem[chk[i]]); end
    end
    cyc();
  endtask

  task automatic test_random();
    bit if_pend, dm_pend, g_if, g_dm;
    bit exp_if_rv, exp_dm_rv, exp_err;
    int denied;
    int e_if, e_dm, e_cf;
    logic [DATA_W-1:0] e;
    // Seed words 0..15 and the last in-range word.
    for (int i = 0; i <= 16; i++) begin
      dm_req = 1'b1; dm_we = 1'b1;
      dm_addr = (i == 16) ? 9'(DEPTH - 1) : 9'(i);
      dm_wdata = $urandom;
      @(negedge clk1);
      n_cmp++; if (dm_gnt !== 1'b1) begin
        n_bad++; $display("FAIL rnd_seed%0d_gnt got %b exp 1", i, dm_gnt); end
      cyc();
      ref_mem[dm_addr] = dm_wdata; exp_dm_cnt++;
    end
    idle();
    cyc();
    if_pend = 0; dm_pend = 0; denied = 0;
    exp_if_rv = 0; exp_dm_rv = 0; exp_err = 0;
    for (int c = 0; c <= 300; c++) begin
      // Score the returns of last cycle's grant.
      n_cmp++; if ({if_rvalid, dm_rvalid, addr_err} !== {exp_if_rv, exp_dm_rv, exp_err}) begin
        n_bad++; $display("FAIL rnd_c%0d_flags got if_rv=%b dm_rv=%b err=%b exp %b %b %b",
          c, if_rvalid, dm_rvalid, addr_err, exp_if_rv, exp_dm_rv, exp_err); end
      if (exp_if_rv && if_q.size() > 0) begin
        e = if_q.pop_front();
        n_cmp++; if (if_rdata !== e) begin
          n_bad++; $display("FAIL rnd_c%0d_if_data got %h exp %h", c, if_rdata, e); end
      end
      if (exp_dm_rv && dm_q.size() > 0) begin
        e = dm_q.pop_front();
        n_cmp++; if (dm_rdata !== e) begin
          n_bad++; $display("FAIL rnd_c%0d_dm_data got %h exp %h", c, dm_rdata, e); end
      end
      exp_if_rv = 0; exp_dm_rv = 0; exp_err = 0;
      if (c == 300) break;
      // New requests; pending ones stay held.
      if (!if_pend) begin
        if_req = ($urandom_range(0, 9) < 6);
        if_addr = ($urandom_range(0, 19) < 18) ? 9'($urandom_range(0, 15)) : 9'($urandom_range(500, 511));
        if_pend = if_req;
      end
      if (!dm_pend) begin
        dm_req = ($urandom_range(0, 9) < 6);
        dm_we = $urandom_range(0, 1);
        dm_addr = ($urandom_range(0, 19) < 18) ? 9'($urandom_range(0, 15)) : 9'($urandom_range(500, 511));
        dm_wdata = $urandom;
        dm_pend = dm_req;
      end
      @(negedge clk1);
      g_if = if_req && (denied == MAX_WAIT || !dm_req);
      g_dm = dm_req && !g_if;
      n_cmp++; if ({if_gnt, dm_gnt} !== {g_if, g_dm}) begin
        n_bad++; $display("FAIL rnd_c%0d_gnt got if=%b dm=%b exp if=%b dm=%b", c, if_gnt, dm_gnt, g_if, g_dm); end
      if (if_req && dm_req) exp_conf_cnt++;
      if (g_if) begin
        exp_if_cnt++; if_pend = 0; exp_if_rv = 1;
        exp_err = (int'(if_addr) >= DEPTH);
        if_q.push_back(exp_err ? '0 : ref_mem[if_addr]);
      end
      if (g_dm) begin
        exp_dm_cnt++; dm_pend = 0;
        exp_err = (int'(dm_addr) >= DEPTH);
        if (dm_we) begin
          if (!exp_err) ref_mem[dm_addr] = dm_wdata;
        end else begin
          exp_dm_rv = 1;
          dm_q.push_back(exp_err ? '0 : ref_mem[dm_addr]);
        end
      end
      denied = (if_req && !g_if) ? ((denied < MAX_WAIT) ? denied + 1 : MAX_WAIT) : 0;
      cyc();
      if (!if_pend) if_req = 1'b0;
      if (!dm_pend) dm_req = 1'b0;
    end
    idle();
    cyc();
    e_if = exp_if_cnt; e_dm = exp_dm_cnt; e_cf = exp_conf_cnt;
`ifndef ARB_STATS_EN
    e_if = 0; e_dm = 0; e_cf = 0;
`endif
    n_cmp++; if ({stat_if_cnt, stat_dm_cnt, stat_conf_cnt} !== {e_if[15:0], e_dm[15:0], e_cf[15:0]}) begin
      n_bad++; $display("FAIL rnd_stats got %0d/%0d/%0d exp %0d/%0d/%0d",
        stat_if_cnt, stat_dm_cnt, stat_conf_cnt, e_if, e_dm, e_cf); end
  endtask

  task automatic test_reset_mid();
    logic [DATA_W-1:0] keep;
    keep = ref_mem[5];
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 9'd5;
    @(negedge clk1);
    n_cmp++; if (dm_gnt !== 1'b1) begin
      n_bad++; $display("FAIL rstmid_load_gnt got %b exp 1", dm_gnt); end
    cyc();
    // Reset arrives with the read in flight and a store presented.
    reset = 1'b1; dm_we = 1'b1; dm_wdata = ~keep;
    #1;
    n_cmp++; if (dm_rvalid !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_rvalid got %b exp 0", dm_rvalid); end
    cyc();
    idle();
    n_cmp++; if ({dm_rvalid, cpu_stall, state_dbg} !== 4'b0000) begin
      n_bad++; $display("FAIL rstmid_state got rv=%b stall=%b st=%0d exp 0 0 0", dm_rvalid, cpu_stall, state_dbg); end
    reset = 1'b0;
    exp_if_cnt = 0; exp_dm_cnt = 0; exp_conf_cnt = 0;
    n_cmp++; if ({stat_if_cnt, stat_dm_cnt, stat_conf_cnt} !== 48'd0) begin
      n_bad++; $display("FAIL rstmid_stats got %h exp 0", {stat_if_cnt, stat_dm_cnt, stat_conf_cnt}); end
    if_req = 1'b1; if_addr = 9'd5;
    @(negedge clk1);
    n_cmp++; if (if_gnt !== 1'b1) begin
      n_bad++; $display("FAIL rstmid_fetch_gnt got %b exp 1", if_gnt); end
    cyc();
    if_req = 1'b0;
    n_cmp++; if (if_rvalid !== 1'b1 || if_rdata !== keep) begin
      n_bad++; $display("FAIL rstmid_word_kept got v=%b d=%h exp v=1 d=%h", if_rvalid, if_rdata, keep); end
    cyc();
  endtask

  initial begin
    test_reset();
    test_store_fetch();
    test_starvation();
    test_loader();
    test_out_of_range();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
